pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset (word aligned).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 stall  input  1  hold all state this cycle.
REQ-005 br_valid  input  1  instruction at pc is a Bicc or CALL.
REQ-006 br_taken  input  1  branch condition true; ignored unless br_valid.
REQ-007 br_annul  input  1  annul (a) bit of the branch.
REQ-008 br_uncond  input  1  branch is BA or CALL.
REQ-009 disp_sel  input  1  0 = disp22 in disp[21:0]; 1 = disp30 (CALL).
REQ-010 disp  input  30  word displacement field.
REQ-011 jmpl_valid  input  1  JMPL/RETT redirect request.
REQ-012 jmpl_target  input  32  register-computed jump target.
REQ-013 trap_valid  input  1  trap redirect request.
REQ-014 trap_vector  input  32  trap handler address.
REQ-015 pc  output  32  address of the instruction currently executing.
REQ-016 npc  output  32  address of the next instruction.
REQ-017 annul_slot  output  1  instruction at pc is squashed; no architectural effect.
REQ-018 misalign_err  output  1  one-cycle pulse: JMPL target low bits nonzero.

Function
REQ-019 The block SHALL implement SPARC delayed control transfer: each non-stalled cycle pc<=npc; npc<=next_npc.
REQ-020 Default next_npc SHALL be npc+4, modulo 2^32.
REQ-021 The branch target SHALL be pc + (sign-extended 30-bit displacement << 2), modulo 2^32; disp22 is sign-extended from bit 21; disp30 is used as is.
REQ-022 With br_valid and (br_taken or br_uncond), next_npc SHALL equal the branch target.
REQ-023 The delay slot SHALL be annulled when br_annul=1 and either the branch is not taken, or the branch is BA (br_uncond=1 and disp_sel=0); CALL never annuls.
REQ-024 jmpl_valid with jmpl_target[1:0]=0 SHALL set next_npc=jmpl_target; the delay slot executes.
REQ-025 A misaligned jmpl_target SHALL pulse misalign_err for one cycle and leave the advance at default.
REQ-026 trap_valid SHALL load pc<=trap_vector and npc<=trap_vector+4 with no delay slot, and clear annul_slot.
REQ-027 Priority SHALL be stall > trap > jmpl > branch > default.
REQ-028 Requests arriving while annul_slot=1 (from the squashed instruction) SHALL be ignored, except trap_valid.
REQ-029 The FSM SHALL use three states:
- BOOT: the first cycle after reset; annul_slot=0; goes to RUN.
- RUN: normal issue; goes to ANNUL when REQ-023 holds.
- ANNUL: annul_slot=1 for exactly one issued slot; goes to RUN; a trap goes to RUN.
REQ-030 While stalled, the state and all outputs SHALL hold, and misalign_err SHALL be 0.
REQ-031 All outputs SHALL be registered, with latency one cycle from the request to the updated pc/npc.

Reset
REQ-032 On rst_n low: pc=RESET_PC, npc=RESET_PC+4, annul_slot=0, misalign_err=0, state=BOOT, immediately and independent of clk.
REQ-033 Reset mid-annul or mid-redirect SHALL discard the pending transfer.

Structure
REQ-034 The shared datapath package SHALL hold the state encoding (BOOT/RUN/ANNUL), the word size (32) and the disp widths (22/30).
REQ-035 A sub-module branch_target_calc SHALL hold the combinational sign-extension and adder.

Verification
REQ-036 Reset with RESET_PC=0, then 3 idle cycles -> pc 0,4,8,12; npc = pc+4.
REQ-037 At pc=0x100, a taken BNE with disp22=0x3FFFFE -> the next cycle is pc=0x104 (slot executes), then pc=0xF8.
REQ-038 At pc=0x200, an untaken branch with a=1 -> the slot at 0x204 has annul_slot=1, then pc=0x208; BA with a=1 and disp=4 -> the slot is annulled, then pc=0x210.
REQ-039 CALL with disp30=0x1000_0000 at pc=5<<2 -> the target wraps modulo 2^32 to 0x4000_0014; the slot is not annulled.
REQ-040 JMPL to 0x302 -> misalign_err pulses one cycle and pc advances by 4; JMPL to 0x300 -> the slot executes, then pc=0x300.
REQ-041 trap_valid coincident with a taken branch and stall=0 -> pc=trap_vector, npc=trap_vector+4; with stall=1 -> pc and npc hold.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: word and displacement widths
// and the sequencer state encoding.
package pc_sequencer_pkg;

   localparam int WORD_W   = 32;
   localparam int DISP22_W = 22;
   localparam int DISP30_W = 30;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ANNUL = 2'd2
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_branch_target_calc.sv
// PC-relative branch/call target: sign-extend the word displacement to
// 30 bits, scale to bytes and add to pc (wraps modulo 2^32).
module branch_target_calc
   import pc_sequencer_pkg::*;
(
   input  logic [WORD_W-1:0]   pc,
   input  logic                disp_sel,
   input  logic [DISP30_W-1:0] disp,
   output logic [WORD_W-1:0]   target
);

   logic [DISP30_W-1:0] disp_ext;

   // disp22 is sign-extended from bit 21; disp30 already spans the full word range
   always_comb begin
      disp_ext = disp;
      if (!disp_sel)
         disp_ext = {{(DISP30_W-DISP22_W){disp[DISP22_W-1]}}, disp[DISP22_W-1:0]};
   end

   assign target = pc + {disp_ext, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// SPARC-style delayed control transfer sequencer. pc/npc advance every
// non-stalled cycle; branches, JMPL and traps redirect npc (or both for a
// trap). The instruction in an annulled delay slot cannot redirect.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic        br_annul,
   input  logic        br_uncond,
   input  logic        disp_sel,
   input  logic [29:0] disp,
   input  logic        jmpl_valid,
   input  logic [31:0] jmpl_target,
   input  logic        trap_valid,
   input  logic [31:0] trap_vector,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        annul_slot,
   output logic        misalign_err
);

   seq_state_t  state;
   logic [31:0] br_target;
   logic [31:0] next_npc;
   logic        annul_next;
   logic        mis_next;
   logic        live;
   logic        taken_eff;

   branch_target_calc u_btc (
      .pc       (pc),
      .disp_sel (disp_sel),
      .disp     (disp),
      .target   (br_target)
   );

   // BA/CALL count as taken regardless of br_taken
   assign taken_eff = br_taken | br_uncond;
   // a squashed slot has no architectural effect, so its requests are dropped
   assign live      = (state != ST_ANNUL);

   // next-npc selection: jmpl beats branch; misaligned jmpl falls back to npc+4
   always_comb begin
      next_npc   = npc + 32'd4;
      annul_next = 1'b0;
      mis_next   = 1'b0;
      if (live) begin
         if (jmpl_valid) begin
            if (jmpl_target[1:0] == 2'b00)
               next_npc = jmpl_target;
            else
               mis_next = 1'b1;
         end else if (br_valid) begin
            if (taken_eff)
               next_npc = br_target;
            // untaken with a=1, or BA with a=1, squashes the slot; CALL never does
            annul_next = br_annul & (~taken_eff | (br_uncond & ~disp_sel));
         end
      end
   end

   // sequencer FSM with registered pc/npc/annul/misalign; trap overrides all but stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         npc          <= RESET_PC + 32'd4;
         annul_slot   <= 1'b0;
         misalign_err <= 1'b0;
         state        <= ST_BOOT;
      end else if (stall) begin
         misalign_err <= 1'b0;
      end else if (trap_valid) begin
         pc           <= trap_vector;
         npc          <= trap_vector + 32'd4;
         annul_slot   <= 1'b0;
         misalign_err <= 1'b0;
         state        <= ST_RUN;
      end else begin
         pc           <= npc;
         npc          <= next_npc;
         annul_slot   <= annul_next;
         misalign_err <= mis_next;
         case (state)
            ST_BOOT, ST_RUN: state <= annul_next ? ST_ANNUL : ST_RUN;
            default:         state <= ST_RUN;
         endcase
      end
   end

endmodule
